// File: rtl/act_lut_controller.sv
// Load/evaluate controller for the activation-function unit: streams coefficient
// tables into LUT slots and forwards evaluations with 1-cycle latency, blocking the slot being reloaded.
module act_lut_controller #(
    parameter int Q_INT         = 8,
    parameter int Q_FRAC        = 8,
    parameter int ACT_MASK_SIZE = 4,
    parameter int ACT_LUT_DEPTH = 4,
    parameter int ACT_LUT_SIZE  = 32,
    localparam int Q_SIZE       = Q_INT + Q_FRAC
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_cfg_start,
    input  logic [ACT_MASK_SIZE-1:0]               i_cfg_mask,
    input  logic                                   i_cfg_abort,
    input  logic                                   i_cfg_valid,
    input  logic [ACT_LUT_SIZE-1:0]                i_cfg_data,
    output logic                                   o_cfg_ready,
    output logic                                   o_cfg_busy,
    output logic                                   o_cfg_done,
    input  logic                                   i_in_valid,
    input  logic [Q_SIZE-1:0]                      i_in_x,
    input  logic [ACT_MASK_SIZE-1:0]               i_in_mask,
    output logic                                   o_in_ready,
    output logic                                   o_out_valid,
    output logic [Q_SIZE-1:0]                      o_out_fx,
    output logic [Q_SIZE-1:0]                      o_act_x,
    output logic [ACT_MASK_SIZE-1:0]               o_act_mask,
    input  logic [Q_SIZE-1:0]                      i_act_fx,
    output logic                                   o_act_write_enable,
    output logic [ACT_MASK_SIZE+ACT_LUT_DEPTH-1:0] o_act_write_addr,
    output logic [ACT_LUT_SIZE-1:0]                o_act_write_data
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ACT_LUT_DEPTH-1:0] r_idx;
    logic [ACT_MASK_SIZE-1:0] r_load_mask;
    logic [Q_SIZE-1:0]        r_act_x;
    logic [ACT_MASK_SIZE-1:0] r_act_mask;
    logic                     r_out_valid;
    logic                     w_beat;
    logic                     w_last;
    logic                     w_accept;

    // Abort takes priority over a coincident data beat.
    assign w_beat   = (r_state == S_LOAD) && i_cfg_valid && !i_cfg_abort;
    assign w_last   = (r_idx == {ACT_LUT_DEPTH{1'b1}});
    assign w_accept = i_in_valid && o_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_load_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_cfg_start) begin
                r_idx       <= '0;
                r_load_mask <= i_cfg_mask;
            end else if (w_beat) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_cfg_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (i_cfg_abort)          w_state_nxt = S_IDLE;
                else if (w_beat && w_last) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_cfg_ready        = (r_state == S_LOAD);
    assign o_cfg_busy         = (r_state == S_LOAD) || (r_state == S_DONE);
    assign o_cfg_done         = (r_state == S_DONE);
    assign o_act_write_enable = w_beat;
    assign o_act_write_addr   = {r_load_mask, r_idx};
    assign o_act_write_data   = i_cfg_data;

    // Only the slot under reload is blocked; every other mask passes, including non-LUT functions.
    assign o_in_ready = !(o_cfg_busy && (i_in_mask == r_load_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_x     <= '0;
            r_act_mask  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_act_x    <= i_in_x;
                r_act_mask <= i_in_mask;
            end
        end
    end

    // Passthrough on accept so the unit sees the operand this cycle; otherwise hold the last one.
    assign o_act_x     = w_accept ? i_in_x    : r_act_x;
    assign o_act_mask  = w_accept ? i_in_mask : r_act_mask;
    assign o_out_valid = r_out_valid;
    assign o_out_fx    = i_act_fx;

endmodule

// File: tb/tb_act_lut_controller.sv
// Directed bench for act_lut_controller; the activation unit is a stub returning x + mask one cycle later.
module tb_act_lut_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_valid = 1'b0;
    logic [3:0]  cfg_mask = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_ready, cfg_busy, cfg_done;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = '0;
    logic [3:0]  in_mask = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_fx, act_x, act_fx;
    logic [3:0]  act_mask;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int last_wr_cyc = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    act_lut_controller dut (
        .clk(clk), .rst(rst),
        .i_cfg_start(cfg_start), .i_cfg_mask(cfg_mask), .i_cfg_abort(cfg_abort),
        .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data),
        .o_cfg_ready(cfg_ready), .o_cfg_busy(cfg_busy), .o_cfg_done(cfg_done),
        .i_in_valid(in_valid), .i_in_x(in_x), .i_in_mask(in_mask), .o_in_ready(in_ready),
        .o_out_valid(out_valid), .o_out_fx(out_fx),
        .o_act_x(act_x), .o_act_mask(act_mask), .i_act_fx(act_fx),
        .o_act_write_enable(we), .o_act_write_addr(wa), .o_act_write_data(wd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        act_fx <= act_x + {12'd0, act_mask};
    end

    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(wa);
            wd_q.push_back(wd);
            last_wr_cyc = cyc;
        end
        if (cfg_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check_eq("rst_ready", cfg_ready, 0);
        check_eq("rst_busy", cfg_busy, 0);
        check_eq("rst_done", cfg_done, 0);
        check_eq("rst_outv", out_valid, 0);
        check_eq("rst_actx", act_x, 0);
        check_eq("rst_actm", act_mask, 0);
        check_eq("rst_we", we, 0);
        check_eq("rst_inrdy", in_ready, 1);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        clear_log();

        // Full load of slot 0 with back-to-back beats
        cfg_start = 1'b1; cfg_mask = 4'h0; start_cyc = cyc;
        for (int i = 0; i < 16; i++) begin
            next_cyc();
            cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'h1000_0000 + 32'(i);
            if (i == 0) begin
                @(negedge clk);
                check_eq("full_ready_c1", cfg_ready, 1);
                check_eq("full_busy_c1", cfg_busy, 1);
            end
        end
        next_cyc();
        cfg_valid = 1'b0; in_mask = 4'h0;
        @(negedge clk);
        check_eq("full_done_c17", cfg_done, 1);
        check_eq("full_busy_c17", cfg_busy, 1);
        check_eq("full_ready_c17", cfg_ready, 0);
        check_eq("full_blk_c17", in_ready, 0);
        next_cyc();
        @(negedge clk);
        check_eq("full_busy_c18", cfg_busy, 0);
        check_eq("full_done_c18", cfg_done, 0);
        check_eq("full_inrdy_c18", in_ready, 1);
        check_eq("full_nwr", wa_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("full_addr%0d", i), wa_q[i], 64'(i));
            check_eq($sformatf("full_data%0d", i), wd_q[i], 64'h1000_0000 + 64'(i));
        end
        check_eq("full_done_cnt", done_cnt, 1);
        check_eq("full_done_lat", done_cyc - start_cyc, 17);

        // Slot 2 load with cfg_valid toggling
        clear_log();
        next_cyc();
        cfg_start = 1'b1; cfg_mask = 4'h2;
        for (int j = 0; j < 31; j++) begin
            next_cyc();
            cfg_start = 1'b0;
            cfg_valid = (j % 2 == 0);
            cfg_data  = (j % 2 == 0) ? 32'h2000_0000 + 32'(j / 2) : 32'hDEAD_BEEF;
        end
        next_cyc();
        cfg_valid = 1'b0;
        next_cyc();
        next_cyc();
        check_eq("tog_nwr", wa_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("tog_addr%0d", i), wa_q[i], 64'h20 + 64'(i));
            check_eq($sformatf("tog_data%0d", i), wd_q[i], 64'h2000_0000 + 64'(i));
        end
        check_eq("tog_done_cnt", done_cnt, 1);
        check_eq("tog_done_after_last", done_cyc - last_wr_cyc, 1);

        // Slot 3 load with concurrent evaluations
        clear_log();
        cfg_start = 1'b1; cfg_mask = 4'h3;
        next_cyc();
        cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'h3000_0000;
        in_valid = 1'b1; in_mask = 4'h3; in_x = 16'h0300;
        @(negedge clk);
        check_eq("blk3_c1", in_ready, 0);
        next_cyc();
        cfg_data = 32'h3000_0001; in_mask = 4'h5; in_x = 16'h0200;
        @(negedge clk);
        check_eq("m5_ready", in_ready, 1);
        check_eq("m5_actx", act_x, 16'h0200);
        check_eq("m5_actm", act_mask, 4'h5);
        next_cyc();
        cfg_data = 32'h3000_0002; in_valid = 1'b0; in_mask = 4'h3;
        @(negedge clk);
        check_eq("m5_outv", out_valid, 1);
        check_eq("m5_outfx", out_fx, 16'h0205);
        check_eq("m5_hold_actx", act_x, 16'h0200);
        in_valid = 1'b1; in_x = 16'h0300;
        for (int b = 3; b < 16; b++) begin
            next_cyc();
            cfg_data = 32'h3000_0000 + 32'(b);
            @(negedge clk);
            check_eq($sformatf("blk3_b%0d", b), in_ready, 0);
        end
        next_cyc();
        cfg_valid = 1'b0;
        @(negedge clk);
        check_eq("blk3_done", in_ready, 0);
        check_eq("l3_done", cfg_done, 1);
        next_cyc();
        @(negedge clk);
        check_eq("blk3_release", in_ready, 1);
        next_cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("m3_outv", out_valid, 1);
        check_eq("m3_outfx", out_fx, 16'h0303);

        // Identity stream, back-to-back
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            in_valid = (k < 3);
            in_mask  = 4'h4;
            in_x     = (k == 0) ? 16'h0100 : (k == 1) ? 16'hFF00 : 16'h0080;
            @(negedge clk);
            if (k >= 1) begin
                check_eq($sformatf("id_outv%0d", k), out_valid, 1);
                check_eq($sformatf("id_outfx%0d", k), out_fx,
                         (k == 1) ? 16'h0104 : (k == 2) ? 16'hFF04 : 16'h0084);
            end
        end
        next_cyc();
        @(negedge clk);
        check_eq("id_outv_end", out_valid, 0);

        // Abort coincident with the beat at idx 5, then restart
        clear_log();
        next_cyc();
        cfg_start = 1'b1; cfg_mask = 4'h1;
        for (int b = 0; b < 5; b++) begin
            next_cyc();
            cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'h5000_0000 + 32'(b);
        end
        next_cyc();
        cfg_abort = 1'b1; cfg_data = 32'h5000_0005;
        @(negedge clk);
        check_eq("abort_we", we, 0);
        next_cyc();
        cfg_abort = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", cfg_busy, 0);
        check_eq("abort_ready", cfg_ready, 0);
        check_eq("abort_nwr", wa_q.size(), 5);
        check_eq("abort_done_cnt", done_cnt, 0);
        next_cyc();
        cfg_start = 1'b1;
        next_cyc();
        cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'hAAAA_0000;
        @(negedge clk);
        check_eq("restart_we", we, 1);
        check_eq("restart_addr", wa, 8'h10);
        check_eq("restart_data", wd, 32'hAAAA_0000);
        next_cyc();
        cfg_valid = 1'b0; cfg_abort = 1'b1;
        next_cyc();
        cfg_abort = 1'b0;

        // Reset at idx 9 with an evaluation in flight
        clear_log();
        next_cyc();
        cfg_start = 1'b1; cfg_mask = 4'h6;
        for (int b = 0; b < 9; b++) begin
            next_cyc();
            cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'h6000_0000 + 32'(b);
            in_valid = (b == 8); in_mask = 4'h4; in_x = 16'h0011;
        end
        next_cyc();
        in_valid = 1'b0; cfg_data = 32'h6000_0009;
        #1;
        check_eq("rstmid_outv_pre", out_valid, 1);
        check_eq("rstmid_we_pre", we, 1);
        rst = 1'b1;
        #1;
        check_eq("rstmid_outv", out_valid, 0);
        check_eq("rstmid_we", we, 0);
        check_eq("rstmid_busy", cfg_busy, 0);
        check_eq("rstmid_ready", cfg_ready, 0);
        check_eq("rstmid_actx", act_x, 0);
        check_eq("rstmid_actm", act_mask, 0);
        check_eq("rstmid_inrdy", in_ready, 1);
        next_cyc();
        cfg_valid = 1'b0;
        next_cyc();
        rst = 1'b0;
        next_cyc();
        @(negedge clk);
        check_eq("rstmid_nwr", wa_q.size(), 9);
        check_eq("rstmid_done_cnt", done_cnt, 0);
        check_eq("rstmid_idle", cfg_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
